palette_lookup: RTL

Pixel-side colour resolution stage that sits directly upstream of the palette RAM's read port (port B) and consumes its read data. Each incoming pixel carries a 10-bit palette index. The stage issues the palette read, delays the video timing signals to match the RAM latency, and substitutes a backdrop colour for transparent pixels. It then applies a global 4-bit fade and presents registered 24-bit RGB to the display output logic.

---
 rtl/palette_lookup.sv | 93 +++++++++
 1 files changed

// File: rtl/palette_lookup.sv
// palette_lookup: issues palette port B reads, substitutes backdrop for transparent pixels, applies 4-bit fade.
// Latency 2 cycles (input N -> rgb/timing at N+2); no backpressure, one pixel accepted every clock.
module palette_lookup #(
  parameter int NUM_CHANNELS = 3,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                      clk,
  input  logic                      _reset,
  input  logic                      pixel_valid,
  input  logic [ADDR_WIDTH-1:0]     pixel_index,
  input  logic                      pixel_transparent,
  input  logic                      blank_in,
  input  logic                      h_sync_in,
  input  logic                      v_sync_in,
  input  logic [8*NUM_CHANNELS-1:0] backdrop_color,
  input  logic [3:0]                fade_level,
  output logic                      pal_rd,
  output logic [ADDR_WIDTH-1:0]     pal_addr,
  input  logic [8*NUM_CHANNELS-1:0] pal_data,
  output logic [8*NUM_CHANNELS-1:0] rgb_out,
  output logic                      rgb_valid,
  output logic                      blank_out,
  output logic                      h_sync_out,
  output logic                      v_sync_out
);

  localparam int DW = 8 * NUM_CHANNELS;

  typedef struct packed {
    logic valid;
    logic transparent;
    logic blank;
    logic h_sync;
    logic v_sync;
  } ctl_t;

  ctl_t          s1_ctl;
  logic [DW-1:0] s1_backdrop;
  logic [3:0]    s1_fade;

  logic [DW-1:0] src_color;
  logic [DW-1:0] faded;
  logic [4:0]    factor;
  logic          show;

  // Transparent or blanked pixels never touch the palette.
  assign pal_addr = pixel_index;
  assign pal_rd   = pixel_valid & ~pixel_transparent & ~blank_in;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      s1_ctl      <= '0;
      s1_backdrop <= '0;
      s1_fade     <= '0;
    end else begin
      s1_ctl      <= '{valid:       pixel_valid,
                       transparent: pixel_transparent,
                       blank:       blank_in,
                       h_sync:      h_sync_in,
                       v_sync:      v_sync_in};
      s1_backdrop <= backdrop_color;
      s1_fade     <= fade_level;
    end
  end

  // pal_data lines up with the stage-1 copy of the pixel that requested it.
  assign src_color = s1_ctl.transparent ? s1_backdrop : pal_data;
  assign factor    = 5'd16 - {1'b0, s1_fade};
  assign show      = s1_ctl.valid & ~s1_ctl.blank;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [12:0] prod;
    assign prod = {5'd0, src_color[8*i +: 8]} * {8'd0, factor};
    assign faded[8*i +: 8] = 8'(prod >> 4);
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rgb_out    <= '0;
      rgb_valid  <= 1'b0;
      blank_out  <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      rgb_out    <= show ? faded : '0;
      rgb_valid  <= show;
      blank_out  <= s1_ctl.blank;
      h_sync_out <= s1_ctl.h_sync;
      v_sync_out <= s1_ctl.v_sync;
    end
  end

endmodule
